// File: rtl/wb_arbiter.sv
// ============================================================================
// Module      : wb_arbiter
// Description : Round-robin arbiter sharing a registered writeback bus between
//               NREQ execution units, each fronted by a one-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_error,
    input  logic [NREQ*8-1:0] req_robid,
    input  logic [NREQ*6-1:0] req_rd,
    input  logic [NREQ*32-1:0] req_result,
    input  logic              rob_flush,
    output logic              wb_valid,
    output logic              wb_error,
    output logic [7:0]        wb_robid,
    output logic [5:0]        wb_rd,
    output logic [31:0]       wb_result,
    output logic [2:0]        wb_grant_id
);

    logic [NREQ-1:0] buf_valid;
    logic            buf_error  [NREQ];
    logic [7:0]      buf_robid  [NREQ];
    logic [5:0]      buf_rd     [NREQ];
    logic [31:0]     buf_result [NREQ];

    logic [2:0]      rr_ptr;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    int              gsel;
    int              sel;
    logic [NREQ-1:0] accept;

    // Search starts one past the last winner so each full buffer waits at
    // most NREQ-1 other grants.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        gsel      = 0;
        sel       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            sel = (int'(rr_ptr) + k) % NREQ;
            if (!grant_any && !rob_flush && buf_valid[sel]) begin
                grant[sel] = 1'b1;
                grant_any  = 1'b1;
                gsel       = sel;
            end
        end
    end

    assign req_ready = {NREQ{~rob_flush}} & (~buf_valid | grant);
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= '0;
            for (int i = 0; i < NREQ; i++) begin
                buf_error[i]  <= 1'b0;
                buf_robid[i]  <= '0;
                buf_rd[i]     <= '0;
                buf_result[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (rob_flush) begin
                    buf_valid[i] <= 1'b0;
                end else if (accept[i]) begin
                    // Load wins over drain so a granted buffer can refill in the same edge.
                    buf_valid[i]  <= 1'b1;
                    buf_error[i]  <= req_error[i];
                    buf_robid[i]  <= req_robid[8*i +: 8];
                    buf_rd[i]     <= req_rd[6*i +: 6];
                    buf_result[i] <= req_result[32*i +: 32];
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_error    <= 1'b0;
            wb_robid    <= '0;
            wb_rd       <= '0;
            wb_result   <= '0;
            wb_grant_id <= '0;
            rr_ptr      <= 3'(NREQ - 1);
        end else if (grant_any) begin
            wb_valid    <= 1'b1;
            wb_error    <= buf_error[gsel];
            wb_robid    <= buf_robid[gsel];
            wb_rd       <= buf_rd[gsel];
            wb_result   <= buf_result[gsel];
            wb_grant_id <= 3'(gsel);
            rr_ptr      <= 3'(gsel);
        end else begin
            wb_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed and randomized checks of wb_arbiter against a
//               cycle-level behavioural model of the buffers and the bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_error;
    logic [NREQ*8-1:0]  req_robid;
    logic [NREQ*6-1:0]  req_rd;
    logic [NREQ*32-1:0] req_result;
    logic               rob_flush;
    logic               wb_valid;
    logic               wb_error;
    logic [7:0]         wb_robid;
    logic [5:0]         wb_rd;
    logic [31:0]        wb_result;
    logic [2:0]         wb_grant_id;

    wb_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_error  (req_error),
        .req_robid  (req_robid),
        .req_rd     (req_rd),
        .req_result (req_result),
        .rob_flush  (rob_flush),
        .wb_valid   (wb_valid),
        .wb_error   (wb_error),
        .wb_robid   (wb_robid),
        .wb_rd      (wb_rd),
        .wb_result  (wb_result),
        .wb_grant_id(wb_grant_id)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one slot per requester, last winner, expected bus.
    bit          m_full [NREQ];
    bit          m_err  [NREQ];
    bit [7:0]    m_rob  [NREQ];
    bit [5:0]    m_rd   [NREQ];
    bit [31:0]   m_res  [NREQ];
    int          m_last;
    bit          e_valid, e_err;
    bit [7:0]    e_rob;
    bit [5:0]    e_rd;
    bit [31:0]   e_res;
    bit [2:0]    e_gid;
    logic [NREQ-1:0] obs_ready;
    logic [NREQ-1:0] exp_ready;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_full[i] = 0; m_err[i] = 0; m_rob[i] = 0; m_rd[i] = 0; m_res[i] = 0;
        end
        m_last = NREQ - 1;
        e_valid = 0; e_err = 0; e_rob = 0; e_rd = 0; e_res = 0; e_gid = 0;
    endtask

    function automatic int model_winner();
        if (rob_flush) return -1;
        for (int k = 1; k <= NREQ; k++)
            if (m_full[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        return -1;
    endfunction

    task automatic check_bus();
        chk("wb_valid",    wb_valid,    e_valid);
        chk("wb_error",    wb_error,    e_err);
        chk("wb_robid",    wb_robid,    e_rob);
        chk("wb_rd",       wb_rd,       e_rd);
        chk("wb_result",   wb_result,   e_res);
        chk("wb_grant_id", wb_grant_id, e_gid);
    endtask

    // One clock: check ready mid-cycle, advance model over the edge, check bus.
    task automatic step();
        int w;
        @(negedge clk);
        w = model_winner();
        for (int i = 0; i < NREQ; i++)
            exp_ready[i] = !rob_flush && (!m_full[i] || w == i);
        obs_ready = req_ready;
        chk("req_ready", req_ready, exp_ready);
        @(posedge clk);
        if (w >= 0) begin
            e_valid = 1; e_err = m_err[w]; e_rob = m_rob[w]; e_rd = m_rd[w];
            e_res = m_res[w]; e_gid = 3'(w); m_last = w;
        end else begin
            e_valid = 0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rob_flush) m_full[i] = 0;
            else if (req_valid[i] && exp_ready[i]) begin
                m_full[i] = 1; m_err[i] = req_error[i]; m_rob[i] = req_robid[8*i +: 8];
                m_rd[i] = req_rd[6*i +: 6]; m_res[i] = req_result[32*i +: 32];
            end else if (w == i) m_full[i] = 0;
        end
        #1;
        check_bus();
    endtask

    task automatic set_req(input int i, input logic v, input logic e,
                           input logic [7:0] rob, input logic [5:0] rd, input logic [31:0] res);
        req_valid[i] = v;
        req_error[i] = e;
        req_robid[8*i +: 8]   = rob;
        req_rd[6*i +: 6]      = rd;
        req_result[32*i +: 32] = res;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        rob_flush = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    logic [2:0] prev_gid;

    initial begin
        rst = 1'b1; rob_flush = 1'b0; req_valid = '0; req_error = '0;
        req_robid = '0; req_rd = '0; req_result = '0;
        model_reset();
        #12;
        check_bus();
        chk("reset_ready", req_ready, 4'hF);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Single request on requester 2
        set_req(2, 1, 0, 8'h15, 6'h23, 32'hDEADBEEF);
        step();
        req_valid = '0;
        step();
        chk("single_valid", wb_valid, 1'b1);
        chk("single_robid", wb_robid, 8'h15);
        chk("single_rd", wb_rd, 6'h23);
        chk("single_result", wb_result, 32'hDEADBEEF);
        chk("single_gid", wb_grant_id, 3'd2);
        step();
        chk("single_done", wb_valid, 1'b0);

        // Contention after reset: robid order 0,1,2,3
        rst = 1'b1; #1; model_reset(); @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 8'(i), 6'(i + 32), 32'(i * 7));
        step();
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            step();
            chk("cont_robid", wb_robid, 8'(i));
            chk("cont_ready3", obs_ready[3], (i == 3) ? 1'b1 : 1'b0);
        end
        idle(2);

        // Fairness: requesters 0 and 3 refill every cycle
        for (int k = 0; k < 10; k++) begin
            set_req(0, 1, 0, 8'(8'h80 + k), 6'h01, $urandom);
            set_req(3, 1, 1, 8'(8'hC0 + k), 6'h21, $urandom);
            step();
            if (k >= 2) chk("fair_alternate", wb_grant_id != prev_gid, 1'b1);
            prev_gid = wb_grant_id;
        end
        idle(3);

        // Simultaneous drain and refill on requester 1
        set_req(1, 1, 0, 8'h11, 6'h05, 32'h1111_0000);
        step();
        set_req(1, 1, 0, 8'h40, 6'h06, 32'h4040_4040);
        step();
        chk("refill_ready", obs_ready[1], 1'b1);
        chk("refill_first", wb_robid, 8'h11);
        req_valid = '0;
        step();
        chk("refill_valid", wb_valid, 1'b1);
        chk("refill_second", wb_robid, 8'h40);
        idle(2);

        // Flush with buffers 0 and 2 full
        set_req(0, 1, 0, 8'hA0, 6'h10, 32'hA0A0_A0A0);
        set_req(2, 1, 0, 8'hA2, 6'h12, 32'hA2A2_A2A2);
        step();
        req_valid = '0;
        rob_flush = 1'b1;
        step();
        chk("flush_ready", obs_ready, 4'h0);
        chk("flush_wb", wb_valid, 1'b0);
        rob_flush = 1'b0;
        set_req(1, 1, 0, 8'hB1, 6'h31, 32'hB1B1_B1B1);
        step();
        chk("postflush_accept", obs_ready[1], 1'b1);
        chk("postflush_nobeat", wb_valid, 1'b0);
        req_valid = '0;
        step();
        chk("postflush_gid", wb_grant_id, 3'd1);
        chk("postflush_robid", wb_robid, 8'hB1);
        step();
        chk("postflush_empty", wb_valid, 1'b0);

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !exp_ready[i]))
                    set_req(i, $urandom_range(0, 2) != 0, 1'($urandom), 8'($urandom),
                            6'($urandom), $urandom);
            end
            rob_flush = ($urandom_range(0, 15) == 0);
            step();
        end

        // Asynchronous reset mid-cycle with buffers full
        rob_flush = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 1, 8'hF0, 6'h3F, 32'hFFFF_0000);
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        #1;
        model_reset();
        check_bus();
        chk("async_reset_ready", req_ready, 4'hF);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
